snoop_bus_ctrl: RTL and testbench

SNOOP_BUS_CTRL -- requirements
Module: snoop_bus_ctrl

---
 rtl/snoop_bus_ctrl.sv | 164 ++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_ctrl.sv
// Two-core snooping bus arbiter: round-robin grant, snoop/invalidate, cache-to-cache forward, unified memory.
// Build option: define SNOOP_FWD_EN to let a snoop hit on a miss be served from the other core's cache.
module snoop_bus_ctrl #(
  parameter int SNOOP_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  read_miss,
  input  logic [1:0]  write_miss,
  input  logic [1:0]  invalidate,
  input  logic [1:0]  u_we,
  input  logic [1:0]  u_re,
  input  logic [12:0] addr0,
  input  logic [12:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic [1:0]  grant,
  output logic [1:0]  u_rdy,
  output logic [15:0] rd_data,
  output logic [1:0]  cpu_search,
  output logic [10:0] BOCI,
  output logic [1:0]  inval_out,
  input  logic [1:0]  cpu_search_found,
  input  logic [15:0] other_proc_data0,
  input  logic [15:0] other_proc_data1,
  output logic [12:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdy
);

  typedef enum logic [1:0] {IDLE, SNOOP, FWD, MEM} state_t;
  typedef enum logic [2:0] {T_INV, T_RM, T_WM, T_RE, T_WE} req_t;

  localparam logic [2:0] LP_WAIT = 3'(SNOOP_WAIT);
`ifdef SNOOP_FWD_EN
  localparam bit LP_FWD = 1'b1;
`else
  localparam bit LP_FWD = 1'b0;
`endif

  state_t      r_state;
  state_t      w_next;
  req_t        r_type;
  req_t        w_type;
  logic        r_core;
  logic        r_ptr;
  logic [12:0] r_addr;
  logic [15:0] r_wdata;
  logic [2:0]  r_cnt;
  logic [10:0] r_boci;

  logic [1:0]  w_req;
  logic        w_any;
  logic        w_win;
  logic        w_other;
  logic        w_done;
  logic        w_snoop_type;
  logic [12:0] w_addr;

  assign w_req   = read_miss | write_miss | invalidate | u_we | u_re;
  assign w_any   = |w_req;
  // Contention is settled by the pointer; a lone requester wins outright.
  assign w_win   = (w_req == 2'b11) ? r_ptr : w_req[1];
  assign w_other = ~r_core;
  assign w_addr  = w_win ? addr1 : addr0;
  assign BOCI    = r_boci;

  always_comb begin
    w_type = T_INV;
    if (u_we[w_win])            w_type = T_WE;
    else if (u_re[w_win])       w_type = T_RE;
    else if (write_miss[w_win]) w_type = T_WM;
    else if (read_miss[w_win])  w_type = T_RM;
  end

  assign w_snoop_type = (w_type == T_WM) || (w_type == T_RM) || (w_type == T_INV);

  always_comb begin
    w_next     = r_state;
    w_done     = 1'b0;
    grant      = 2'b00;
    u_rdy      = 2'b00;
    rd_data    = 16'h0000;
    cpu_search = 2'b00;
    inval_out  = 2'b00;
    mem_addr   = 13'h0000;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 16'h0000;
    unique case (r_state)
      IDLE: begin
        if (w_any) w_next = w_snoop_type ? SNOOP : MEM;
      end
      SNOOP: begin
        grant[r_core] = 1'b1;
        if (r_cnt != LP_WAIT) begin
          cpu_search[w_other] = 1'b1;
        end else begin
          // Sample cycle: the search strobe is down, the hit is read once.
          if ((r_type == T_WM) || (r_type == T_INV)) inval_out[w_other] = 1'b1;
          if (r_type == T_INV) begin
            u_rdy[r_core] = 1'b1;
            w_done        = 1'b1;
            w_next        = IDLE;
          end else if (LP_FWD && cpu_search_found[w_other]) begin
            w_next = FWD;
          end else begin
            w_next = MEM;
          end
        end
      end
      FWD: begin
        grant[r_core] = 1'b1;
        u_rdy[r_core] = 1'b1;
        rd_data       = r_core ? other_proc_data0 : other_proc_data1;
        w_done        = 1'b1;
        w_next        = IDLE;
      end
      MEM: begin
        grant[r_core] = 1'b1;
        mem_addr      = r_addr;
        mem_we        = (r_type == T_WE) && !rst;
        mem_re        = (r_type != T_WE) && !rst;
        mem_wdata     = (r_type == T_WE) ? r_wdata : 16'h0000;
        if (mem_rdy) begin
          u_rdy[r_core] = 1'b1;
          rd_data       = mem_rdata;
          w_done        = 1'b1;
          w_next        = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_type  <= T_INV;
      r_core  <= 1'b0;
      r_ptr   <= 1'b0;
      r_addr  <= 13'h0000;
      r_wdata <= 16'h0000;
      r_cnt   <= 3'd0;
      r_boci  <= 11'h000;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_core  <= w_win;
        r_type  <= w_type;
        r_addr  <= w_addr;
        r_wdata <= w_win ? wdata1 : wdata0;
        r_cnt   <= 3'd0;
        if (w_snoop_type) r_boci <= w_addr[12:2];
      end
      if (r_state == SNOOP && r_cnt != LP_WAIT) r_cnt <= r_cnt + 3'd1;
      if (w_done) r_ptr <= w_other;
    end
  end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Randomized self-checking bench for snoop_bus_ctrl against a transaction-level reference model.
module tb_snoop_bus_ctrl;

  localparam int WAIT = 2;
`ifdef SNOOP_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  read_miss, write_miss, invalidate, u_we, u_re;
  logic [12:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  grant, u_rdy, cpu_search, inval_out, cpu_search_found;
  logic [15:0] rd_data, other_proc_data0, other_proc_data1;
  logic [10:0] BOCI;
  logic [12:0] mem_addr;
  logic        mem_re, mem_we, mem_rdy;
  logic [15:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int memcnt = 0;
  int exp_ptr = 0;

  // Transaction observations
  int ob_lat, ob_search, ob_search_self, ob_inval, ob_inval_self;
  int ob_mem_re, ob_mem_we, ob_addr_bad, ob_wdata_bad, ob_grant_bad, ob_urdy_bad;
  bit ob_timeout;
  logic [15:0] ob_rd, ob_rd_idle;
  logic [10:0] ob_boci;
  logic [1:0]  ob_grant_after;

  snoop_bus_ctrl #(.SNOOP_WAIT(WAIT)) dut (
    .clk(clk), .rst(rst),
    .read_miss(read_miss), .write_miss(write_miss), .invalidate(invalidate),
    .u_we(u_we), .u_re(u_re),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .grant(grant), .u_rdy(u_rdy), .rd_data(rd_data),
    .cpu_search(cpu_search), .BOCI(BOCI), .inval_out(inval_out),
    .cpu_search_found(cpu_search_found),
    .other_proc_data0(other_proc_data0), .other_proc_data1(other_proc_data1),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  // Memory responder: ready in the mem_lat-th cycle of an access.
  always @(posedge clk) begin
    if (mem_re || mem_we) memcnt <= memcnt + 1;
    else                  memcnt <= 0;
  end
  always_comb mem_rdy = (mem_re || mem_we) && (memcnt == mem_lat - 1);

  // Type index: 4=u_we, 3=u_re, 2=write_miss, 1=read_miss, 0=invalidate
  function automatic int eff_type(input logic [4:0] m);
    if (m[4]) return 4;
    if (m[3]) return 3;
    if (m[2]) return 2;
    if (m[1]) return 1;
    return 0;
  endfunction

  function automatic bit is_fwd(input int t, input bit found);
    return (t == 1 || t == 2) && found && FWD_EN;
  endfunction

  function automatic int model_lat(input int t, input bit found, input int lat);
    int snoop_part;
    snoop_part = (t <= 2) ? WAIT + 1 : 0;
    if (t == 0) return snoop_part;
    if (is_fwd(t, found)) return snoop_part + 1;
    return snoop_part + lat;
  endfunction

  task automatic clr_req(input int core);
    u_we[core] = 1'b0; u_re[core] = 1'b0; write_miss[core] = 1'b0;
    read_miss[core] = 1'b0; invalidate[core] = 1'b0;
  endtask

  task automatic run_txn(input int core, input logic [4:0] mask, input logic [12:0] addr,
                         input logic [15:0] wd, input bit found, input int lat,
                         input logic [15:0] od, input logic [15:0] mrd, input bit drop_early);
    int oth;
    logic [1:0] exp_g;
    oth = 1 - core;
    ob_lat = -1; ob_search = 0; ob_search_self = 0; ob_inval = 0; ob_inval_self = 0;
    ob_mem_re = 0; ob_mem_we = 0; ob_addr_bad = 0; ob_wdata_bad = 0; ob_grant_bad = 0;
    ob_urdy_bad = 0; ob_timeout = 1'b1; ob_rd = 16'h0; ob_boci = 11'h0;
    @(posedge clk); #1;
    if (core == 0) begin addr0 = addr; wdata0 = wd; end
    else begin addr1 = addr; wdata1 = wd; end
    u_we[core] = mask[4]; u_re[core] = mask[3]; write_miss[core] = mask[2];
    read_miss[core] = mask[1]; invalidate[core] = mask[0];
    cpu_search_found = {found, found};
    other_proc_data0 = od; other_proc_data1 = ~od;
    mem_rdata = mrd; mem_lat = lat;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      exp_g = 2'b00;
      if (c != 0) exp_g[core] = 1'b1;
      if (grant !== exp_g) ob_grant_bad++;
      if (cpu_search[oth]) begin ob_search++; ob_boci = BOCI; end
      if (cpu_search[core]) ob_search_self++;
      if (inval_out[oth]) ob_inval++;
      if (inval_out[core]) ob_inval_self++;
      if (mem_re) ob_mem_re++;
      if (mem_we) begin ob_mem_we++; if (mem_wdata !== wd) ob_wdata_bad++; end
      if ((mem_re || mem_we) && mem_addr !== addr) ob_addr_bad++;
      if (u_rdy[oth]) ob_urdy_bad++;
      if (drop_early && c == 1) clr_req(core);
      if (u_rdy[core]) begin
        ob_lat = c; ob_rd = rd_data; ob_timeout = 1'b0;
        clr_req(core);
        break;
      end
    end
    if (ob_timeout) clr_req(core);
    @(negedge clk);
    ob_grant_after = grant;
    ob_rd_idle = rd_data;
    exp_ptr = 1 - core;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {read_miss, write_miss, invalidate, u_we, u_re} = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    cpu_search_found = '0; other_proc_data0 = '0; other_proc_data1 = '0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant, u_rdy, cpu_search, inval_out, BOCI, rd_data, mem_addr, mem_re, mem_we, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b u_rdy=%b cs=%b inv=%b boci=%h rd=%h ma=%h re=%b we=%b wd=%h, want all 0",
               grant, u_rdy, cpu_search, inval_out, BOCI, rd_data, mem_addr, mem_re, mem_we, mem_wdata);
    end
    exp_ptr = 0;
  endtask

  task automatic two_core(input int lat, output int first, output int rdy1, output int start2,
                          output int rdy2, output int both);
    bit done0, done1;
    first = -1; rdy1 = -1; start2 = -1; rdy2 = -1; both = 0; done0 = 0; done1 = 0;
    @(posedge clk); #1;
    addr0 = 13'($urandom); addr1 = 13'($urandom);
    mem_lat = lat;
    u_re = 2'b11;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (grant == 2'b11) both++;
      if (first < 0 && grant != 2'b00) first = grant[1] ? 1 : 0;
      if (first >= 0 && start2 < 0 && grant[1 - first]) start2 = c;
      for (int k = 0; k < 2; k++) begin
        if (u_rdy[k]) begin
          u_re[k] = 1'b0;
          if (k == first) rdy1 = c; else rdy2 = c;
          if (k == 0) done0 = 1; else done1 = 1;
        end
      end
      if (done0 && done1) break;
    end
    u_re = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int first, rdy1, start2, rdy2, both, lat, want_first;
    lat = 2;
    want_first = exp_ptr;
    two_core(lat, first, rdy1, start2, rdy2, both);
    checks++; if (first !== want_first) begin errors++; $display("FAIL b2b_first: got core %0d want %0d", first, want_first); end
    checks++; if (rdy1 !== lat) begin errors++; $display("FAIL b2b_rdy1: got cycle %0d want %0d", rdy1, lat); end
    checks++; if (start2 !== lat + 2) begin errors++; $display("FAIL b2b_grant2: got cycle %0d want %0d", start2, lat + 2); end
    checks++; if (rdy2 !== 2 * lat + 1) begin errors++; $display("FAIL b2b_rdy2: got cycle %0d want %0d", rdy2, 2 * lat + 1); end
    checks++; if (both !== 0) begin errors++; $display("FAIL b2b_both_grant: got %0d cycles want 0", both); end
    exp_ptr = first;
  endtask

  task automatic test_rr();
    int first, rdy1, start2, rdy2, both;
    run_txn(0, 5'b01000, 13'h0123, 16'h0, 1'b0, 1, 16'h0, 16'h5555, 1'b0);
    checks++; if (ob_lat !== 1) begin errors++; $display("FAIL rr_solo_lat: got %0d want 1", ob_lat); end
    two_core(1, first, rdy1, start2, rdy2, both);
    checks++; if (first !== exp_ptr) begin errors++; $display("FAIL rr_first: got core %0d want %0d", first, exp_ptr); end
    checks++; if (both !== 0) begin errors++; $display("FAIL rr_both_grant: got %0d want 0", both); end
    exp_ptr = first;
  endtask

  task automatic test_read_miss_spec();
    logic [15:0] want_rd;
    int want_re;
    run_txn(0, 5'b00010, 13'h0104, 16'h0, 1'b1, 3, 16'h4110, 16'h1234, 1'b0);
    // Core 1 returns ~od = 0xBEEF.
    want_rd = FWD_EN ? 16'hBEEF : 16'h1234;
    want_re = FWD_EN ? 0 : 3;
    checks++; if (ob_boci !== 11'h041) begin errors++; $display("FAIL rm_boci: got %h want 041", ob_boci); end
    checks++; if (ob_rd !== want_rd) begin errors++; $display("FAIL rm_rd_data: got %h want %h", ob_rd, want_rd); end
    checks++; if (ob_mem_re !== want_re) begin errors++; $display("FAIL rm_mem_re_cycles: got %0d want %0d", ob_mem_re, want_re); end
    checks++; if (ob_addr_bad !== 0) begin errors++; $display("FAIL rm_mem_addr: got %0d bad cycles want 0", ob_addr_bad); end
    checks++; if (ob_search !== WAIT) begin errors++; $display("FAIL rm_search: got %0d want %0d", ob_search, WAIT); end
  endtask

  task automatic test_invalidate();
    run_txn(1, 5'b00001, 13'h1FFC, 16'h0, 1'b1, 2, 16'h0, 16'h0, 1'b0);
    checks++; if (ob_search !== WAIT) begin errors++; $display("FAIL inv_search: got %0d want %0d", ob_search, WAIT); end
    checks++; if (ob_inval !== 1) begin errors++; $display("FAIL inv_pulse: got %0d want 1", ob_inval); end
    checks++; if (ob_lat !== WAIT + 1) begin errors++; $display("FAIL inv_lat: got %0d want %0d", ob_lat, WAIT + 1); end
    checks++; if (ob_mem_re + ob_mem_we !== 0) begin errors++; $display("FAIL inv_mem: got %0d want 0", ob_mem_re + ob_mem_we); end
    checks++; if (ob_boci !== 11'h7FF) begin errors++; $display("FAIL inv_boci: got %h want 7ff", ob_boci); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (BOCI !== 11'h7FF || rd_data !== 16'h0 || grant !== 2'b00) begin
        errors++; $display("FAIL idle_hold: got boci=%h rd=%h grant=%b want 7ff 0000 00", BOCI, rd_data, grant);
      end
    end
  endtask

  task automatic test_random();
    int core, t, lat, wl;
    logic [4:0] mask;
    logic [12:0] a;
    logic [15:0] wd, od, mrd, want_rd;
    bit found, drop;
    for (int n = 0; n < 40; n++) begin
      core = $urandom_range(0, 1); mask = 5'($urandom_range(1, 31)); a = 13'($urandom);
      wd = 16'($urandom); od = 16'($urandom); mrd = 16'($urandom);
      found = 1'($urandom); drop = 1'($urandom); lat = $urandom_range(1, 4);
      t = eff_type(mask);
      run_txn(core, mask, a, wd, found, lat, od, mrd, drop);
      wl = model_lat(t, found, lat);
      want_rd = is_fwd(t, found) ? (core == 0 ? ~od : od) : mrd;
      checks++; if (ob_timeout || ob_lat !== wl) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d (t=%0d)", n, ob_lat, wl, t); end
      if (t != 0) begin
        checks++; if (ob_rd !== want_rd) begin errors++; $display("FAIL rnd_rd[%0d]: got %h want %h", n, ob_rd, want_rd); end
      end
      checks++; if (ob_search !== ((t <= 2) ? WAIT : 0) || ob_search_self !== 0) begin
        errors++; $display("FAIL rnd_search[%0d]: got %0d/%0d want %0d/0", n, ob_search, ob_search_self, (t <= 2) ? WAIT : 0); end
      checks++; if (ob_inval !== ((t == 0 || t == 2) ? 1 : 0) || ob_inval_self !== 0) begin
        errors++; $display("FAIL rnd_inval[%0d]: got %0d/%0d", n, ob_inval, ob_inval_self); end
      checks++; if (ob_mem_re !== ((t == 3 || ((t == 1 || t == 2) && !is_fwd(t, found))) ? lat : 0)) begin
        errors++; $display("FAIL rnd_mem_re[%0d]: got %0d cycles (t=%0d lat=%0d)", n, ob_mem_re, t, lat); end
      checks++; if (ob_mem_we !== ((t == 4) ? lat : 0)) begin errors++; $display("FAIL rnd_mem_we[%0d]: got %0d", n, ob_mem_we); end
      checks++; if (ob_addr_bad + ob_wdata_bad !== 0) begin errors++; $display("FAIL rnd_mem_bus[%0d]: got %0d bad cycles want 0", n, ob_addr_bad + ob_wdata_bad); end
      checks++; if (ob_grant_bad + ob_urdy_bad !== 0 || ob_grant_after !== 2'b00) begin
        errors++; $display("FAIL rnd_grant[%0d]: got bad=%0d after=%b want 0 00", n, ob_grant_bad + ob_urdy_bad, ob_grant_after); end
      checks++; if (ob_rd_idle !== 16'h0) begin errors++; $display("FAIL rnd_idle_rd[%0d]: got %h want 0", n, ob_rd_idle); end
      if (t <= 2) begin
        checks++; if (ob_boci !== a[12:2]) begin errors++; $display("FAIL rnd_boci[%0d]: got %h want %h", n, ob_boci, a[12:2]); end
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    int seen;
    @(posedge clk); #1;
    addr0 = 13'h0AAA; wdata0 = 16'hC0DE; mem_lat = 1000;
    u_we[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (mem_we) seen++; end
    checks++; if (seen !== 3) begin errors++; $display("FAIL rstm_precond: got %0d mem_we cycles want 3", seen); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL rstm_drop: got we=%b re=%b want 0 0", mem_we, mem_re); end
    @(posedge clk); #1 rst = 1'b0; mem_lat = 2;
    @(negedge clk);
    checks++;
    if ({grant, u_rdy, cpu_search, inval_out, BOCI, rd_data, mem_addr, mem_re, mem_we, mem_wdata} !== '0) begin
      errors++; $display("FAIL rstm_outputs: got grant=%b boci=%h ma=%h we=%b wd=%h want all 0", grant, BOCI, mem_addr, mem_we, mem_wdata);
    end
    @(negedge clk);
    checks++; if (grant !== 2'b01 || mem_we !== 1'b1) begin errors++; $display("FAIL rstm_rearb: got grant=%b we=%b want 01 1", grant, mem_we); end
    seen = -1;
    for (int c = 0; c < 20; c++) begin
      if (u_rdy[0]) begin seen = c; u_we[0] = 1'b0; break; end
      @(negedge clk);
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL rstm_done: got u_rdy after %0d cycles want 1", seen); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_read_miss_spec();
    test_invalidate();
    test_rr();
    test_random();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
